// File: rtl/parity_pkg.sv
// Shared definitions for the parity/popcount check block.
//   clog2_p1(n)  : bits needed to hold the values 0..n (width of a ones count)
//   MAX_N        : widest input word the block is built for
//   parity_res_t : one result record {p, ones_cnt}, sized for MAX_N
package parity_pkg;

   localparam int MAX_N = 64;

   function automatic int clog2_p1(input int n);
      return $clog2(n + 1);
   endfunction

   typedef struct packed {
      logic                         p;
      logic [clog2_p1(MAX_N)-1:0]   ones_cnt;
   } parity_res_t;

endpackage

// File: rtl/parity_logic_popcount_tree.sv
// Combinational popcount of an N-bit word, built as a balanced binary
// adder tree.
//   a   : input word (N bits)
//   cnt : number of 1s in a (CNT_W bits, range 0..N)
// The leaves are padded to the next power of two with zeros. The nodes are
// stored heap-style: level l occupies indices (2**l)-1 .. (2**(l+1))-2, and
// the root is node[0]. Every node is CNT_W wide. Because no partial sum can
// exceed N, no node can overflow.
module popcount_tree
   import parity_pkg::*;
#(
   parameter int   N     = 4,
   localparam int  CNT_W = clog2_p1(N)
) (
   input  logic [N-1:0]     a,
   output logic [CNT_W-1:0] cnt
);

   localparam int LEVELS = $clog2(N);
   localparam int LEAVES = 1 << LEVELS;

   logic [CNT_W-1:0] node [2*LEAVES-1];

   genvar i, l, j;

   for (i = 0; i < LEAVES; i++) begin : g_leaf
      if (i < N) begin : g_real
         assign node[LEAVES-1+i] = CNT_W'(a[i]);
      end else begin : g_pad
         assign node[LEAVES-1+i] = '0;
      end
   end

   for (l = LEVELS - 1; l >= 0; l--) begin : g_level
      for (j = 0; j < (1 << l); j++) begin : g_node
         localparam int IDX = (1 << l) - 1 + j;
         assign node[IDX] = node[2*IDX+1] + node[2*IDX+2];
      end
   end

   assign cnt = node[0];

endmodule

// File: rtl/parity_logic.sv
// Registered parity detector and ones counter for an N-bit word.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : A is sampled on an edge only when high
//   A         : data word (N bits, unsigned)
//   out_valid : one-cycle pulse for each sampled word
//   P         : 1 when the sampled A had an odd number of 1s
//   ones_cnt  : number of 1s in the sampled A (0..N)
// P is computed by its own XOR reduction, in parallel with the adder tree,
// so that the parity path does not wait for the full count to settle.
module parity_logic
   import parity_pkg::*;
#(
   parameter int   N     = 4,
   localparam int  CNT_W = clog2_p1(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [N-1:0]     A,
   output logic             out_valid,
   output logic             P,
   output logic [CNT_W-1:0] ones_cnt
);

   if (N < 1 || N > MAX_N) begin : g_bad_n
      $error("parity_logic: N out of range 1..64");
   end

   logic [N-1:0]     a_qual;
   logic [CNT_W-1:0] cnt_tree;

   logic             p_q, p_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;

   // A is forced to zero when it is not being sampled. This keeps an
   // undriven or X input out of the datapath while the block is idle.
   assign a_qual = in_valid ? A : '0;

   popcount_tree #(.N(N)) u_popcount (
      .a   (a_qual),
      .cnt (cnt_tree)
   );

   always_comb begin
      p_d         = p_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         p_d         = ^a_qual;
         cnt_d       = cnt_tree;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q         <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         p_q         <= p_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign P         = p_q;
   assign ones_cnt  = cnt_q;
   assign out_valid = out_valid_q;

   // The XOR-reduced parity must always agree with the count's LSB.
   a_parity_matches_cnt : assert property (@(posedge clk) P == ones_cnt[0]);

endmodule

// File: tb/tb_parity_logic.sv
module tb_parity_logic;
   import parity_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        v4 = 1'b0, v1 = 1'b0, v64 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [0:0]  a1 = '0;
   logic [63:0] a64 = '0;

   logic        ov4, ov1, ov64, p4, p1, p64;
   logic [2:0]  c4;
   logic [0:0]  c1;
   logic [6:0]  c64;

   always #5 clk = ~clk;

   parity_logic #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .A(a4),
      .out_valid(ov4), .P(p4), .ones_cnt(c4));
   parity_logic #(.N(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .A(a1),
      .out_valid(ov1), .P(p1), .ones_cnt(c1));
   parity_logic #(.N(64)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(v64), .A(a64),
      .out_valid(ov64), .P(p64), .ones_cnt(c64));

   int n_checks = 0;
   int n_fail   = 0;

   parity_res_t sbq [3][$];
   parity_res_t held [3];

   typedef struct {
      logic [3:0] a;
      logic       p;
      logic [2:0] cnt;
   } vec_t;
   vec_t tbl [5];

   function automatic parity_res_t ref_model(input logic [63:0] a, input int w);
      parity_res_t r;
      int c = 0;
      for (int k = 0; k < w; k++) if (a[k]) c++;
      r.ones_cnt = 7'(c);
      r.p        = (c % 2) == 1;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_dut(input int d);
      logic       ov, p;
      logic [6:0] c;
      string      nm;
      case (d)
         0: begin ov = ov4;  p = p4;  c = {4'b0, c4}; end
         1: begin ov = ov1;  p = p1;  c = {6'b0, c1}; end
         default: begin ov = ov64; p = p64; c = c64; end
      endcase
      nm = $sformatf("dut%0d", d);
      if (sbq[d].size() > 0) begin
         held[d] = sbq[d].pop_front();
         chk({nm, " out_valid"}, 64'(ov), 64'd1);
      end else begin
         chk({nm, " out_valid"}, 64'(ov), 64'd0);
      end
      chk({nm, " P"}, 64'(p), 64'(held[d].p));
      chk({nm, " ones_cnt"}, 64'(c), 64'(held[d].ones_cnt));
      chk({nm, " P==cnt[0]"}, 64'(p), 64'(c[0]));
   endtask

   task automatic clear_model();
      for (int d = 0; d < 3; d++) begin
         sbq[d].delete();
         held[d] = '0;
      end
   endtask

   // One clock: expectations for words captured on this edge are queued,
   // then the outputs are checked 1 time unit after the edge.
   task automatic cycle();
      if (!rst) begin
         if (v4)  sbq[0].push_back(ref_model({60'b0, a4}, 4));
         if (v1)  sbq[1].push_back(ref_model({63'b0, a1}, 1));
         if (v64) sbq[2].push_back(ref_model(a64, 64));
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) check_dut(d);
   endtask

   initial begin
      tbl[0] = '{4'b0000, 1'b0, 3'd0};
      tbl[1] = '{4'b0001, 1'b1, 3'd1};
      tbl[2] = '{4'b0110, 1'b0, 3'd2};
      tbl[3] = '{4'b1110, 1'b1, 3'd3};
      tbl[4] = '{4'b1111, 1'b0, 3'd4};
      clear_model();

      // 1. reset with a live word presented
      #1 rst = 1'b1;
      v4 = 1'b1; a4 = 4'b1011;
      #1;
      for (int d = 0; d < 3; d++) check_dut(d);
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      chk("reset release P", 64'(p4), 64'd1);
      chk("reset release cnt", 64'(c4), 64'd3);

      // 2. directed table for N=4
      for (int i = 0; i < 5; i++) begin
         v4 = 1'b1; a4 = tbl[i].a;
         cycle();
         chk($sformatf("table[%0d] P", i), 64'(p4), 64'(tbl[i].p));
         chk($sformatf("table[%0d] cnt", i), 64'(c4), 64'(tbl[i].cnt));
      end

      // 3. hold while idle, including an X word
      v4 = 1'b1; a4 = 4'b0111;
      cycle();
      v4 = 1'b0; a4 = 4'b1111;
      repeat (3) cycle();
      a4 = 4'bxxxx;
      cycle();
      chk("hold P", 64'(p4), 64'd1);
      chk("hold cnt", 64'(c4), 64'd3);

      // 4. asynchronous reset between edges
      v4 = 1'b1; a4 = 4'b0001;
      cycle();
      a4 = 4'b0111;
      #2 rst = 1'b1;
      clear_model();
      #1;
      chk("async rst P", 64'(p4), 64'd0);
      chk("async rst cnt", 64'(c4), 64'd0);
      chk("async rst out_valid", 64'(ov4), 64'd0);
      cycle();
      rst = 1'b0;
      v4 = 1'b0;
      cycle();

      // 5. random words on all three widths, then boundaries
      for (int i = 0; i < 16; i++) begin
         v4  = ($urandom_range(0, 3) != 0);
         v1  = ($urandom_range(0, 3) != 0);
         v64 = ($urandom_range(0, 3) != 0);
         a4  = 4'($urandom);
         a1  = 1'($urandom);
         a64 = {$urandom, $urandom};
         cycle();
      end
      v4 = 1'b1; v1 = 1'b1; v64 = 1'b1;
      a4 = '1; a1 = 1'b1; a64 = '1;
      cycle();
      chk("N64 all ones cnt", 64'(c64), 64'd64);
      chk("N64 all ones P", 64'(p64), 64'd0);
      chk("N1 one P", 64'(p1), 64'd1);
      a1 = 1'b0; a64 = '0;
      cycle();
      chk("N1 zero P", 64'(p1), 64'd0);
      chk("N64 zero cnt", 64'(c64), 64'd0);
      v4 = 1'b0; v1 = 1'b0; v64 = 1'b0;
      cycle();

      for (int d = 0; d < 3; d++)
         chk($sformatf("dut%0d scoreboard drained", d), 64'(sbq[d].size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
